dec_unbinder_pack: RTL and testbench
====================================

# dec_unbinder_pack

Sequential inverse of the encoder binder pack. Captures one bound hypervector and undoes the per-feature circular shift, one feature per beat, for a window of `NUM_FEAT` consecutive features starting at `BASE`. Each unbound hypervector is streamed out over a valid/ready handshake. It sits on the decode/query side of the sparse HDC datapath and feeds level-matching logic.

## Interface
- `HV_DIM`, package value: hypervector width in bits.
- `NUM_FEAT`, 10: features handled by this pack.
- `BASE`, 0: index of the first feature. Feature i uses shift `SHIFTS[BASE+i]` from the package.
- `IDX_W`, `$clog2(NUM_FEAT)`: width of the feature index.

- `clk` in 1: single clock, all logic on the rising edge.
- `nrst` in 1: reset, synchronous, active-low.
- `start_decoding` in 1: start request; sampled only in IDLE.
- `bound_hv` in `HV_DIM`: bound vector, captured on an accepted start.
- `busy` out 1: high from the cycle after an accepted start until done.
- `out_valid` out 1: `unbound_hv`/`out_idx` are valid.
- `out_ready` in 1: downstream accepts the beat.
- `out_idx` out `IDX_W`: feature index i (0..`NUM_FEAT`-1).
- `unbound_hv` out `HV_DIM`: `bound_hv` rotated right by `SHIFTS[BASE+i] mod HV_DIM`.
- `done` out 1: one-cycle pulse after the last beat is accepted.

## Operation
- The encoder binder rotates left by SHIFT, so the unbinder rotates right by the same amount:
  - `unbound_hv[j] = hv_reg[(j + s) mod HV_DIM]`, with `s = SHIFTS[BASE+i] mod HV_DIM`.
  - s = 0 means pass-through.
- States: IDLE, STREAM, FIN.
  - **IDLE:** `busy=0`, `out_valid=0`. When `start_decoding=1`: capture `bound_hv` into `hv_reg`, clear the index, go to STREAM.
  - **STREAM:** `busy=1`, `out_valid=1`. When `out_valid && out_ready`:
    - if `idx == NUM_FEAT-1`: go to FIN;
    - else `idx++`.
  - **FIN:** `done=1` for exactly one cycle, `busy=0`, `out_valid=0`, then back to IDLE.
- `unbound_hv` is registered. It is computed from `hv_reg` and the next index so that it is aligned with `out_valid`.
  - Compare the per-index shift values against the package table.
- `start_decoding` is ignored in STREAM and FIN. There is no queueing, and `hv_reg` does not change.
- `bound_hv` changes after capture have no effect.

## Timing
- Reset (`nrst=0` at a clock edge):
  - state = IDLE, `busy=0`, `out_valid=0`, `done=0`, `out_idx=0`, `unbound_hv=0`, `hv_reg=0`.
- Reset asserted mid-stream aborts immediately. No `done` is produced, and the next beat requires a new start.
- Start accepted at edge t:
  - `out_valid=1`, `out_idx=0` from t+1 (latency 1).
- Beats: with `out_ready` held high, one beat per cycle.
  - Indices 0..`NUM_FEAT`-1 occupy t+1..t+`NUM_FEAT`.
  - `done` is high at cycle t+`NUM_FEAT`+1.
  - IDLE at t+`NUM_FEAT`+2; the earliest next start is accepted at that edge.
- Backpressure: while `out_valid && !out_ready`, `out_idx` and `unbound_hv` hold stable.
- `out_valid` never drops before acceptance, and no beat is duplicated or skipped.
- `done` and `out_valid` are never high in the same cycle.
- `start_decoding` in the `done` cycle is ignored.

## Test plan
- **Single-bit vector, ready=1.**
  - Stimulus: `bound_hv` with only bit 0 set.
  - Required: beat i has exactly bit `(HV_DIM - s_i) mod HV_DIM` set; `out_idx` runs 0..9; `done` at t+11.
- **Round trip.**
  - Stimulus: random `level_hv`, rotated left by s_k in the bench (k fixed), presented as `bound_hv`.
  - Required: beat k equals `level_hv` bit-exactly. Popcount is preserved on every beat.
- **Backpressure.**
  - Stimulus: `out_ready` toggling 1,0,0,1,…
  - Required: each index appears exactly once; data is stable during stalls; `done` follows the 10th accepted beat.
- **Start while busy.**
  - Stimulus: pulse `start_decoding` with a different `bound_hv` at beats 3 and 9, and in the `done` cycle.
  - Required: output stream unchanged; exactly one `done`.
- **Reset mid-stream.**
  - Stimulus: `nrst=0` for 1 cycle at index 5.
  - Required: next cycle all outputs are at their reset values; no `done`; a fresh start then produces index 0.
- **Back-to-back runs.**
  - Stimulus: second start at the first IDLE cycle after `done`.
  - Required: accepted; the second stream starts 1 cycle later with the new vector.

Source files
------------

// File: rtl/dec_unbinder_pack.sv
// Decode-side unbinder: captures one bound hypervector and streams NUM_FEAT
// right-rotated copies (one per feature shift) over a valid/ready handshake.

package hdc_pkg;
  localparam int HV_DIM     = 64;
  localparam int NUM_SHIFTS = 16;
  localparam int SHIFTS [NUM_SHIFTS] = '{0, 7, 13, 64, 70, 31, 1, 63, 127, 20, 45, 5, 9, 11, 2, 100};
endpackage

module dec_unbinder_pack #(
  parameter int HV_DIM   = hdc_pkg::HV_DIM,
  parameter int NUM_FEAT = 10,
  parameter int BASE     = 0,
  parameter int IDX_W    = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start_decoding,
  input  logic [HV_DIM-1:0] bound_hv,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_idx,
  output logic [HV_DIM-1:0] unbound_hv,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, STREAM, FIN} state_t;

  state_t            state_reg;
  logic [HV_DIM-1:0] hv_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [HV_DIM-1:0] unbound_reg;
  logic              busy_reg;
  logic              valid_reg;
  logic              done_reg;

  logic [HV_DIM-1:0] rot_src;
  logic [IDX_W-1:0]  sel_idx;
  logic [HV_DIM-1:0] rot_vec [NUM_FEAT];
  logic [HV_DIM-1:0] rot_sel;
  logic              accept;
  logic              last_beat;

  assign accept    = valid_reg && out_ready;
  assign last_beat = (idx_reg == IDX_W'(NUM_FEAT - 1));

  // In IDLE hv_reg is not loaded yet, so beat 0 is rotated straight from the input.
  assign rot_src = (state_reg == IDLE) ? bound_hv : hv_reg;
  assign sel_idx = (state_reg == IDLE) ? '0 : idx_reg + 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FEAT; gi++) begin : g_rot
      localparam int SHIFT_AMT = hdc_pkg::SHIFTS[BASE + gi] % HV_DIM;
      if (SHIFT_AMT == 0) begin : g_pass
        assign rot_vec[gi] = rot_src;
      end else begin : g_shift
        assign rot_vec[gi] = (rot_src >> SHIFT_AMT) | (rot_src << (HV_DIM - SHIFT_AMT));
      end
    end
  endgenerate

  always_comb begin
    rot_sel = '0;
    for (int i = 0; i < NUM_FEAT; i++) begin
      if (sel_idx == IDX_W'(i)) rot_sel = rot_vec[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_reg   <= IDLE;
      hv_reg      <= '0;
      idx_reg     <= '0;
      unbound_reg <= '0;
      busy_reg    <= 1'b0;
      valid_reg   <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_decoding) begin
            hv_reg      <= bound_hv;
            idx_reg     <= '0;
            unbound_reg <= rot_sel;
            busy_reg    <= 1'b1;
            valid_reg   <= 1'b1;
            state_reg   <= STREAM;
          end
        end
        STREAM: begin
          if (accept) begin
            if (last_beat) begin
              busy_reg  <= 1'b0;
              valid_reg <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= FIN;
            end else begin
              idx_reg     <= idx_reg + 1'b1;
              unbound_reg <= rot_sel;
            end
          end
        end
        FIN:     state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy       = busy_reg;
  assign out_valid  = valid_reg;
  assign out_idx    = idx_reg;
  assign unbound_hv = unbound_reg;
  assign done       = done_reg;

endmodule

// File: tb/tb_dec_unbinder_pack.sv
// Randomized self-checking bench for dec_unbinder_pack against a bit-level
// rotation model built from the shift table.

module tb_dec_unbinder_pack;
  localparam int HV    = hdc_pkg::HV_DIM;
  localparam int NF    = 10;
  localparam int IDX_W = $clog2(NF);

  logic             clk;
  logic             nrst;
  logic             start_decoding;
  logic [HV-1:0]    bound_hv;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic [HV-1:0]    unbound_hv;
  logic             done;

  int vectors     = 0;
  int miscompares = 0;

  dec_unbinder_pack #(.NUM_FEAT(NF), .BASE(0)) dut (
    .clk(clk), .nrst(nrst), .start_decoding(start_decoding), .bound_hv(bound_hv),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .unbound_hv(unbound_hv), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
    $fatal(1, "watchdog");
  end

  function automatic logic [HV-1:0] rand_hv();
    logic [HV-1:0] r;
    for (int j = 0; j < HV; j++) r[j] = 1'($urandom() & 1);
    return r;
  endfunction

  function automatic int shift_of(input int i);
    return hdc_pkg::SHIFTS[i] % HV;
  endfunction

  // Model: bit j of beat i is bit (j + s_i) mod HV of the captured vector.
  function automatic logic [HV-1:0] ref_unbind(input logic [HV-1:0] v, input int i);
    logic [HV-1:0] r;
    int s;
    s = shift_of(i);
    for (int j = 0; j < HV; j++) r[j] = v[(j + s) % HV];
    return r;
  endfunction

  function automatic logic [HV-1:0] rot_left(input logic [HV-1:0] v, input int s);
    logic [HV-1:0] r;
    for (int j = 0; j < HV; j++) r[(j + s) % HV] = v[j];
    return r;
  endfunction

  // Called at a negedge in IDLE; returns at the negedge of the first beat.
  task automatic do_start(input logic [HV-1:0] v);
    start_decoding = 1'b1;
    bound_hv       = v;
    @(negedge clk);
    start_decoding = 1'b0;
    bound_hv       = rand_hv();
  endtask

  task automatic test_reset();
    nrst = 1'b0; start_decoding = 1'b1; bound_hv = rand_hv(); out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (out_idx !== '0) begin miscompares++; $display("FAIL reset_idx: got %0d want 0", out_idx); end
    vectors++; if (unbound_hv !== '0) begin miscompares++; $display("FAIL reset_hv: got %h want 0", unbound_hv); end
    start_decoding = 1'b0; nrst = 1'b1;
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_idle: got valid %b want 0", out_valid); end
    $display("test_reset done");
  endtask

  task automatic test_single_bit();
    logic [HV-1:0] v;
    int pos;
    v = '0; v[0] = 1'b1;
    out_ready = 1'b1;
    do_start(v);
    for (int i = 0; i < NF; i++) begin
      pos = (HV - shift_of(i)) % HV;
      vectors++;
      if (out_valid !== 1'b1 || out_idx !== IDX_W'(i) || done !== 1'b0) begin
        miscompares++;
        $display("FAIL single_beat: got valid=%b idx=%0d done=%b want 1/%0d/0", out_valid, out_idx, done, i);
      end
      vectors++;
      if (unbound_hv[pos] !== 1'b1 || $countones(unbound_hv) != 1) begin
        miscompares++;
        $display("FAIL single_bit idx %0d: got %h want only bit %0d", i, unbound_hv, pos);
      end
      $display("single_bit beat %0d hv=%h", i, unbound_hv);
      @(negedge clk);
    end
    vectors++;
    if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_done: got done=%b valid=%b busy=%b want 1/0/0", done, out_valid, busy);
    end
    @(negedge clk);
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL single_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_round_trip(input int k);
    logic [HV-1:0] level, b;
    level = rand_hv();
    b = rot_left(level, shift_of(k));
    out_ready = 1'b1;
    do_start(b);
    for (int i = 0; i < NF; i++) begin
      vectors++;
      if (unbound_hv !== ref_unbind(b, i) || out_idx !== IDX_W'(i)) begin
        miscompares++;
        $display("FAIL round_beat idx %0d: got %h idx %0d want %h", i, unbound_hv, out_idx, ref_unbind(b, i));
      end
      vectors++;
      if ($countones(unbound_hv) != $countones(level)) begin
        miscompares++;
        $display("FAIL round_popcount idx %0d: got %0d want %0d", i, $countones(unbound_hv), $countones(level));
      end
      if (i == k) begin
        vectors++;
        if (unbound_hv !== level) begin
          miscompares++;
          $display("FAIL round_trip k %0d: got %h want %h", k, unbound_hv, level);
        end
      end
      @(negedge clk);
    end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL round_done: got %b want 1", done); end
    $display("round_trip k=%0d level=%h", k, level);
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [HV-1:0]    v, prev_hv;
    logic [IDX_W-1:0] prev_idx;
    logic             pat [4];
    int               k, c;
    bit               stalled, got_done;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    v = rand_hv();
    out_ready = 1'b0;
    do_start(v);
    k = 0; c = 0; stalled = 0; got_done = 0;
    prev_hv = '0; prev_idx = '0;
    while (!got_done && c < 200) begin
      if (k < NF) begin
        vectors++;
        if (out_valid !== 1'b1 || out_idx !== IDX_W'(k) || unbound_hv !== ref_unbind(v, k) || done !== 1'b0) begin
          miscompares++;
          $display("FAIL bp_beat: got valid=%b idx=%0d hv=%h done=%b want 1/%0d/%h/0",
                   out_valid, out_idx, unbound_hv, done, k, ref_unbind(v, k));
        end
        if (stalled) begin
          vectors++;
          if (unbound_hv !== prev_hv || out_idx !== prev_idx) begin
            miscompares++;
            $display("FAIL bp_stable: got idx=%0d hv=%h want idx=%0d hv=%h", out_idx, unbound_hv, prev_idx, prev_hv);
          end
        end
        prev_hv = unbound_hv; prev_idx = out_idx;
        out_ready = pat[c % 4];
        stalled = !out_ready;
        $display("backpressure cycle %0d idx=%0d ready=%b", c, out_idx, out_ready);
        @(negedge clk);
        if (out_ready) k++;
      end else begin
        vectors++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL bp_done: got done=%b valid=%b want 1/0", done, out_valid);
        end
        got_done = 1;
      end
      c++;
    end
    if (!got_done) begin
      vectors++; miscompares++;
      $display("FAIL bp_timeout: accepted %0d beats, want %0d", k, NF);
    end
    out_ready = 1'b1;
    @(negedge clk);
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL bp_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_start_while_busy();
    logic [HV-1:0] v, v2;
    int dones;
    v = rand_hv(); v2 = ~v;
    out_ready = 1'b1;
    dones = 0;
    do_start(v);
    for (int i = 0; i < NF; i++) begin
      if (done === 1'b1) dones++;
      vectors++;
      if (out_idx !== IDX_W'(i) || unbound_hv !== ref_unbind(v, i) || out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL busy_beat: got idx=%0d hv=%h want %0d/%h", out_idx, unbound_hv, i, ref_unbind(v, i));
      end
      start_decoding = (i == 3 || i == 9);
      bound_hv = v2;
      @(negedge clk);
    end
    if (done === 1'b1) dones++;
    start_decoding = 1'b1; bound_hv = v2;
    @(negedge clk);
    start_decoding = 1'b0;
    if (done === 1'b1) dones++;
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_restart: got valid=%b busy=%b want 0/0", out_valid, busy);
    end
    @(negedge clk);
    if (done === 1'b1) dones++;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL busy_idle: got valid %b want 0", out_valid); end
    vectors++; if (dones != 1) begin miscompares++; $display("FAIL busy_done_count: got %0d want 1", dones); end
    $display("start_while_busy done_count=%0d", dones);
  endtask

  task automatic test_reset_mid_stream();
    logic [HV-1:0] v, v2;
    v = rand_hv(); v2 = rand_hv();
    out_ready = 1'b1;
    do_start(v);
    repeat (5) @(negedge clk);
    vectors++; if (out_idx !== IDX_W'(5)) begin miscompares++; $display("FAIL mid_idx: got %0d want 5", out_idx); end
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    vectors++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || out_idx !== '0 || unbound_hv !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: got busy=%b valid=%b done=%b idx=%0d hv=%h want all 0",
               busy, out_valid, done, out_idx, unbound_hv);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_quiet: got done=%b valid=%b want 0/0", done, out_valid);
      end
    end
    do_start(v2);
    vectors++;
    if (out_valid !== 1'b1 || out_idx !== '0 || unbound_hv !== ref_unbind(v2, 0)) begin
      miscompares++;
      $display("FAIL mid_restart: got valid=%b idx=%0d hv=%h want 1/0/%h", out_valid, out_idx, unbound_hv, ref_unbind(v2, 0));
    end
    repeat (NF) @(negedge clk);
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL mid_final_done: got %b want 1", done); end
    @(negedge clk);
    $display("reset_mid_stream done");
  endtask

  task automatic test_back_to_back();
    logic [HV-1:0] v1, v2;
    v1 = rand_hv(); v2 = rand_hv();
    out_ready = 1'b1;
    do_start(v1);
    for (int i = 0; i < NF; i++) begin
      vectors++;
      if (unbound_hv !== ref_unbind(v1, i)) begin
        miscompares++;
        $display("FAIL b2b_first idx %0d: got %h want %h", i, unbound_hv, ref_unbind(v1, i));
      end
      @(negedge clk);
    end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL b2b_done1: got %b want 1", done); end
    @(negedge clk);
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_idle: got valid %b want 0", out_valid); end
    do_start(v2);
    for (int i = 0; i < NF; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_idx !== IDX_W'(i) || unbound_hv !== ref_unbind(v2, i)) begin
        miscompares++;
        $display("FAIL b2b_second idx %0d: got valid=%b idx=%0d hv=%h want %h", i, out_valid, out_idx, unbound_hv, ref_unbind(v2, i));
      end
      @(negedge clk);
    end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL b2b_done2: got %b want 1", done); end
    @(negedge clk);
    $display("back_to_back done");
  endtask

  initial begin
    nrst = 1'b0; start_decoding = 1'b0; bound_hv = '0; out_ready = 1'b0;
    test_reset();
    test_single_bit();
    for (int r = 0; r < 4; r++) test_round_trip(int'($urandom_range(NF - 1, 0)));
    test_round_trip(3);
    test_backpressure();
    test_start_while_busy();
    test_reset_mid_stream();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
